// File: rtl/axi_reg_bridge_if.sv
// 32-bit AXI3 channel bundle as driven by the Zynq GP master port.
// Only the signals the register bridge consumes are carried.
interface axi_if #(
    parameter int AWIDTH = 32,
    parameter int IWIDTH = 12,
    parameter int DWIDTH = 32
);
    logic [IWIDTH-1:0]   awid;
    logic [AWIDTH-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [1:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DWIDTH-1:0]   wdata;
    logic [DWIDTH/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [IWIDTH-1:0]   bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [IWIDTH-1:0]   arid;
    logic [AWIDTH-1:0]   araddr;
    logic [3:0]          arlen;
    logic [1:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [IWIDTH-1:0]   rid;
    logic [DWIDTH-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        input  rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_reg_bridge.sv
// AXI3 slave that turns single/burst reads and writes into one-beat register strobes.
// One transaction in flight; reads and writes share a round-robin grant.
module axi_reg_bridge #(
    parameter int AWIDTH = 32,
    parameter int IWIDTH = 12
) (
    input  logic              clk,
    input  logic              reset,
    axi_if.slave              s,
    output logic [AWIDTH-1:0] reg_addr,
    output logic [31:0]       reg_wdata,
    output logic [3:0]        reg_wstrb,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [31:0]       reg_rdata
);

    typedef enum logic [2:0] {IDLE, WDATA, WRESP, RREQ, RCAP, RDATA} state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [AWIDTH-1:0] ADDR_MASK  = ~AWIDTH'(3);
    localparam logic [AWIDTH-1:0] BEAT_BYTES = AWIDTH'(4);

    state_t              state_reg, state_next;
    logic                awready_reg, awready_next;
    logic                arready_reg, arready_next;
    logic                wready_reg, wready_next;
    logic                bvalid_reg, bvalid_next;
    logic [IWIDTH-1:0]   bid_reg, bid_next;
    logic [1:0]          bresp_reg, bresp_next;
    logic                rvalid_reg, rvalid_next;
    logic [IWIDTH-1:0]   rid_reg, rid_next;
    logic [31:0]         rdata_reg, rdata_next;
    logic [1:0]          rresp_reg, rresp_next;
    logic                rlast_reg, rlast_next;
    logic [AWIDTH-1:0]   addr_reg, addr_next;
    logic [31:0]         wdata_reg, wdata_next;
    logic [3:0]          wstrb_reg, wstrb_next;
    logic                wr_reg, wr_next;
    logic                rd_reg, rd_next;
    logic [IWIDTH-1:0]   id_reg, id_next;
    logic [3:0]          len_reg, len_next;
    logic [1:0]          burst_reg, burst_next;
    logic [3:0]          beat_reg, beat_next;
    logic                err_reg, err_next;
    logic                last_wr_reg, last_wr_next;

    logic                is_last;
    logic                beat_err;
    logic                aw_bad;
    logic                ar_bad;
    logic [AWIDTH-1:0]   step_addr;

    function automatic logic bad_attr(input logic [1:0] burst, input logic [1:0] size);
        return ((burst != BURST_FIXED) && (burst != BURST_INCR)) || (size != SIZE_WORD);
    endfunction

    assign is_last   = (beat_reg == len_reg);
    assign aw_bad    = bad_attr(s.awburst, s.awsize);
    assign ar_bad    = bad_attr(s.arburst, s.arsize);
    assign step_addr = (burst_reg == BURST_INCR) ? addr_reg + BEAT_BYTES : addr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            awready_reg <= 1'b0;
            arready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bid_reg     <= '0;
            bresp_reg   <= '0;
            rvalid_reg  <= 1'b0;
            rid_reg     <= '0;
            rdata_reg   <= '0;
            rresp_reg   <= '0;
            rlast_reg   <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            wr_reg      <= 1'b0;
            rd_reg      <= 1'b0;
            id_reg      <= '0;
            len_reg     <= '0;
            burst_reg   <= '0;
            beat_reg    <= '0;
            err_reg     <= 1'b0;
            last_wr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            awready_reg <= awready_next;
            arready_reg <= arready_next;
            wready_reg  <= wready_next;
            bvalid_reg  <= bvalid_next;
            bid_reg     <= bid_next;
            bresp_reg   <= bresp_next;
            rvalid_reg  <= rvalid_next;
            rid_reg     <= rid_next;
            rdata_reg   <= rdata_next;
            rresp_reg   <= rresp_next;
            rlast_reg   <= rlast_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
            wr_reg      <= wr_next;
            rd_reg      <= rd_next;
            id_reg      <= id_next;
            len_reg     <= len_next;
            burst_reg   <= burst_next;
            beat_reg    <= beat_next;
            err_reg     <= err_next;
            last_wr_reg <= last_wr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        awready_next = 1'b0;
        arready_next = 1'b0;
        wready_next  = wready_reg;
        bvalid_next  = bvalid_reg;
        bid_next     = bid_reg;
        bresp_next   = bresp_reg;
        rvalid_next  = rvalid_reg;
        rid_next     = rid_reg;
        rdata_next   = rdata_reg;
        rresp_next   = rresp_reg;
        rlast_next   = rlast_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        wr_next      = 1'b0;
        rd_next      = 1'b0;
        id_next      = id_reg;
        len_next     = len_reg;
        burst_next   = burst_reg;
        beat_next    = beat_reg;
        err_next     = err_reg;
        last_wr_next = last_wr_reg;
        beat_err     = err_reg;

        case (state_reg)
            IDLE: begin
                // The ready pulse from the previous cycle completes the address handshake here.
                if (awready_reg) begin
                    if (s.awvalid) begin
                        id_next     = s.awid;
                        addr_next   = s.awaddr & ADDR_MASK;
                        len_next    = s.awlen;
                        burst_next  = s.awburst;
                        beat_next   = '0;
                        err_next    = aw_bad;
                        wready_next = 1'b1;
                        state_next  = WDATA;
                    end
                end else if (arready_reg) begin
                    if (s.arvalid) begin
                        id_next    = s.arid;
                        addr_next  = s.araddr & ADDR_MASK;
                        len_next   = s.arlen;
                        burst_next = s.arburst;
                        beat_next  = '0;
                        err_next   = ar_bad;
                        rd_next    = !ar_bad;
                        state_next = RREQ;
                    end
                end else if (s.awvalid && (!s.arvalid || !last_wr_reg)) begin
                    awready_next = 1'b1;
                    last_wr_next = 1'b1;
                end else if (s.arvalid) begin
                    arready_next = 1'b1;
                    last_wr_next = 1'b0;
                end
            end

            WDATA: begin
                if (wready_reg) begin
                    if (s.wvalid) begin
                        beat_err    = err_reg | (s.wlast != is_last);
                        err_next    = beat_err;
                        wdata_next  = s.wdata;
                        wstrb_next  = s.wstrb;
                        wr_next     = !beat_err;
                        wready_next = 1'b0;
                    end
                end else if (is_last) begin
                    bvalid_next = 1'b1;
                    bid_next    = id_reg;
                    bresp_next  = err_reg ? RESP_SLVERR : RESP_OKAY;
                    state_next  = WRESP;
                end else begin
                    // Strobe cycle of the previous beat: step to the next beat address.
                    beat_next   = beat_reg + 4'd1;
                    addr_next   = step_addr;
                    wready_next = 1'b1;
                end
            end

            WRESP: begin
                if (s.bready) begin
                    bvalid_next = 1'b0;
                    state_next  = IDLE;
                end
            end

            RREQ: begin
                state_next = RCAP;
            end

            RCAP: begin
                rdata_next  = err_reg ? 32'h0 : reg_rdata;
                rvalid_next = 1'b1;
                rid_next    = id_reg;
                rresp_next  = err_reg ? RESP_SLVERR : RESP_OKAY;
                rlast_next  = is_last;
                state_next  = RDATA;
            end

            RDATA: begin
                if (s.rready) begin
                    rvalid_next = 1'b0;
                    rlast_next  = 1'b0;
                    if (is_last) begin
                        state_next = IDLE;
                    end else begin
                        beat_next  = beat_reg + 4'd1;
                        addr_next  = step_addr;
                        rd_next    = !err_reg;
                        state_next = RREQ;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign s.awready = awready_reg;
    assign s.arready = arready_reg;
    assign s.wready  = wready_reg;
    assign s.bvalid  = bvalid_reg;
    assign s.bid     = bid_reg;
    assign s.bresp   = bresp_reg;
    assign s.rvalid  = rvalid_reg;
    assign s.rid     = rid_reg;
    assign s.rdata   = rdata_reg;
    assign s.rresp   = rresp_reg;
    assign s.rlast   = rlast_reg;

    assign reg_addr  = addr_reg;
    assign reg_wdata = wdata_reg;
    assign reg_wstrb = wstrb_reg;
    assign reg_wr    = wr_reg;
    assign reg_rd    = rd_reg;

endmodule

// File: tb/tb_axi_reg_bridge.sv
// Directed bench for axi_reg_bridge: expected register strobes and B/R responses are
// queued when stimulus is issued and compared as the DUT produces them.
module tb_axi_reg_bridge;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
    typedef struct packed { logic [11:0] id; logic [1:0] resp; } b_t;
    typedef struct packed { logic [11:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata;

    always #5 clk = ~clk;

    axi_if #(.AWIDTH(32), .IWIDTH(12), .DWIDTH(32)) s_if ();

    axi_reg_bridge #(.AWIDTH(32), .IWIDTH(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (s_if),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wstrb (reg_wstrb),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    wr_t         wr_q[$];
    b_t          b_q[$];
    r_t          r_q[$];
    logic [31:0] rd_q[$];
    bit          hs_aw, hs_ar, hs_w, hs_b, hs_r;
    int          r_seen;
    int          rd_age;
    logic [31:0] aw_addr;
    logic [3:0]  aw_len;
    logic [1:0]  aw_burst;
    bit          aw_err;
    logic [3:0]  ar_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [1:0] burst, input logic [1:0] size);
        return burst[1] || (size != 2'd2);
    endfunction

    // Sampled at the falling edge: handshakes seen here complete on the next rising edge.
    task automatic monitor();
        wr_t ew;
        b_t eb;
        r_t er;
        hs_aw = s_if.awvalid && s_if.awready;
        hs_ar = s_if.arvalid && s_if.arready;
        hs_w  = s_if.wvalid && s_if.wready;
        hs_b  = s_if.bvalid && s_if.bready;
        hs_r  = s_if.rvalid && s_if.rready;
        if (reg_wr || reg_rd) chk("strobe_excl", 64'(reg_wr & reg_rd), 0);
        if (reg_wr) begin
            chk("reg_wr_expected", 64'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) begin
                ew = wr_q.pop_front();
                chk("reg_wr_addr", reg_addr, ew.addr);
                chk("reg_wr_data", reg_wdata, ew.data);
                chk("reg_wr_strb", reg_wstrb, ew.strb);
                $display("reg_wr addr=%h data=%h strb=%h", reg_addr, reg_wdata, reg_wstrb);
            end
        end
        if (reg_rd) begin
            chk("reg_rd_expected", 64'(rd_q.size() > 0), 1);
            if (rd_q.size() > 0) chk("reg_rd_addr", reg_addr, rd_q.pop_front());
            $display("reg_rd addr=%h", reg_addr);
        end
        // Register bank model: data valid only during the cycle after reg_rd.
        if (reg_rd) begin
            reg_rdata = reg_addr ^ 32'hA5A5A5A5;
            rd_age = 1;
        end else if (rd_age == 1) begin
            rd_age = 2;
        end else begin
            reg_rdata = 32'hBADC0DE5;
            rd_age = 0;
        end
        if (hs_b) begin
            chk("b_expected", 64'(b_q.size() > 0), 1);
            if (b_q.size() > 0) begin
                eb = b_q.pop_front();
                chk("bid", s_if.bid, eb.id);
                chk("bresp", s_if.bresp, eb.resp);
            end
            $display("B id=%h resp=%0d", s_if.bid, s_if.bresp);
        end
        if (hs_r) begin
            r_seen++;
            chk("r_expected", 64'(r_q.size() > 0), 1);
            if (r_q.size() > 0) begin
                er = r_q.pop_front();
                chk("rid", s_if.rid, er.id);
                chk("rdata", s_if.rdata, er.data);
                chk("rresp", s_if.rresp, er.resp);
                chk("rlast", s_if.rlast, er.last);
            end
            $display("R id=%h data=%h resp=%0d last=%0d", s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_ctrl"}, 64'({s_if.awready, s_if.wready, s_if.bvalid, s_if.arready,
                                 s_if.rvalid, s_if.rlast, reg_wr, reg_rd}), 0);
        chk({pfx, "_ids"}, 64'({s_if.bid, s_if.rid, s_if.bresp, s_if.rresp}), 0);
        chk({pfx, "_rdata"}, s_if.rdata, 0);
        chk({pfx, "_addr"}, reg_addr, 0);
        chk({pfx, "_wbus"}, 64'({reg_wdata, reg_wstrb}), 0);
    endtask

    task automatic issue_aw(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [1:0] size);
        aw_addr  = addr & ~32'h3;
        aw_len   = len;
        aw_burst = burst;
        aw_err   = is_err(burst, size);
        b_q.push_back('{id: id, resp: aw_err ? 2'b10 : 2'b00});
        s_if.awid = id; s_if.awaddr = addr; s_if.awlen = len;
        s_if.awburst = burst; s_if.awsize = size; s_if.awvalid = 1'b1;
    endtask

    task automatic issue_ar(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [1:0] size);
        logic [31:0] a;
        bit e;
        a = addr & ~32'h3;
        e = is_err(burst, size);
        ar_len = len;
        for (int i = 0; i <= int'(len); i++) begin
            if (!e) rd_q.push_back(a);
            r_q.push_back('{id: id, data: e ? 32'h0 : (a ^ 32'hA5A5A5A5),
                           resp: e ? 2'b10 : 2'b00, last: (i == int'(len))});
            if (burst == INCR) a = a + 32'd4;
        end
        s_if.arid = id; s_if.araddr = addr; s_if.arlen = len;
        s_if.arburst = burst; s_if.arsize = size; s_if.arvalid = 1'b1;
    endtask

    task automatic grant(output bit is_w);
        int n = 0;
        do begin tick(); n++; end while (!hs_aw && !hs_ar && n < 100);
        chk("grant_seen", 64'(hs_aw | hs_ar), 1);
        chk("grant_onehot", 64'(hs_aw & hs_ar), 0);
        is_w = hs_aw;
        if (hs_aw) s_if.awvalid = 1'b0;
        if (hs_ar) s_if.arvalid = 1'b0;
        $display("grant %s", is_w ? "W" : "R");
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input bit last);
        int n = 0;
        if (!aw_err) wr_q.push_back('{addr: aw_addr, data: data, strb: strb});
        s_if.wdata = data; s_if.wstrb = strb; s_if.wlast = last; s_if.wvalid = 1'b1;
        do begin tick(); n++; end while (!hs_w && n < 50);
        chk("w_accept", 64'(hs_w), 1);
        s_if.wvalid = 1'b0;
        s_if.wlast  = 1'b0;
        if (aw_burst == INCR) aw_addr = aw_addr + 32'd4;
    endtask

    task automatic b_phase(input int stall);
        int n = 0;
        b_t eb;
        s_if.bready = (stall == 0);
        if (stall > 0) begin
            do begin tick(); n++; end while (!s_if.bvalid && n < 50);
            chk("b_stall_valid", 64'(s_if.bvalid), 1);
            eb = (b_q.size() > 0) ? b_q[0] : '0;
            for (int k = 0; k < stall; k++) begin
                chk("b_stall_hold", 64'(s_if.bvalid), 1);
                chk("b_stall_payload", 64'({s_if.bid, s_if.bresp}), 64'({eb.id, eb.resp}));
                chk("b_stall_no_ready", 64'(s_if.awready | s_if.arready), 0);
                tick();
            end
            s_if.bready = 1'b1;
            n = 0;
        end
        do begin tick(); n++; end while (!hs_b && n < 50);
        chk("b_handshake", 64'(hs_b), 1);
        s_if.bready = 1'b0;
    endtask

    task automatic r_phase(input int stall);
        int n = 0;
        r_t er;
        r_seen = 0;
        s_if.rready = (stall == 0);
        if (stall > 0) begin
            do begin tick(); n++; end while (!s_if.rvalid && n < 50);
            chk("r_stall_valid", 64'(s_if.rvalid), 1);
            er = (r_q.size() > 0) ? r_q[0] : '0;
            for (int k = 0; k < stall; k++) begin
                chk("r_stall_hold", 64'(s_if.rvalid), 1);
                chk("r_stall_payload", 64'({s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast}),
                    64'({er.id, er.data, er.resp, er.last}));
                chk("r_stall_no_ready", 64'(s_if.awready | s_if.arready), 0);
                tick();
            end
            s_if.rready = 1'b1;
            n = 0;
        end
        do begin tick(); n++; end while (r_seen < int'(ar_len) + 1 && n < 200);
        chk("r_beats", 64'(r_seen), 64'(int'(ar_len) + 1));
        s_if.rready = 1'b0;
    endtask

    task automatic serve(input bit is_w, input int stall);
        if (is_w) begin
            for (int i = 0; i <= int'(aw_len); i++)
                w_beat($urandom, 4'($urandom_range(1, 15)), i == int'(aw_len));
            b_phase(stall);
        end else begin
            r_phase(stall);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit w;
        reset = 1'b1;
        reg_rdata = 32'h0;
        rd_age = 0;
        r_seen = 0;
        s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = '0;
        s_if.awburst = '0; s_if.awvalid = 1'b0;
        s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0;
        s_if.bready = 1'b0;
        s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0;
        s_if.arburst = '0; s_if.arvalid = 1'b0;
        s_if.rready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Single word write.
        issue_aw(12'h123, 32'h4000_0010, 4'd0, INCR, 2'd2);
        grant(w);
        chk("t1_grant_w", 64'(w), 1);
        w_beat(32'hDEAD_BEEF, 4'hF, 1'b1);
        b_phase(0);

        // Four-beat incrementing read.
        issue_ar(12'h00A, 32'h0000_0100, 4'd3, INCR, 2'd2);
        grant(w);
        chk("t2_grant_r", 64'(w), 0);
        serve(w, 0);

        // Simultaneous requests, twice: alternating grant.
        for (int rep = 0; rep < 2; rep++) begin
            issue_aw(12'h301 + 12'(rep), 32'h0000_1000 + 32'(rep * 32'h40), 4'd1, INCR, 2'd2);
            issue_ar(12'h311 + 12'(rep), 32'h0000_2000 + 32'(rep * 32'h40), 4'd1, INCR, 2'd2);
            grant(w);
            chk("t3_order_w", 64'(w), 1);
            serve(w, 0);
            grant(w);
            chk("t3_order_r", 64'(w), 0);
            serve(w, 0);
        end

        // Unsupported attributes, address wrap, FIXED burst, unaligned read.
        issue_aw(12'h044, 32'h0000_0600, 4'd1, WRAP, 2'd2);
        grant(w); serve(w, 0);
        issue_ar(12'h045, 32'h0000_0700, 4'd2, FIXED, 2'd1);
        grant(w); serve(w, 0);
        issue_aw(12'h047, 32'hFFFF_FFFC, 4'd1, INCR, 2'd2);
        grant(w); serve(w, 0);
        issue_ar(12'h046, 32'h0000_0704, 4'd1, FIXED, 2'd2);
        grant(w); serve(w, 0);
        issue_ar(12'h048, 32'h0000_030B, 4'd0, INCR, 2'd2);
        grant(w); serve(w, 0);

        // Response back-pressure with the other channel waiting.
        issue_aw(12'h155, 32'h0000_0A00, 4'd0, INCR, 2'd2);
        issue_ar(12'h156, 32'h0000_0B00, 4'd1, INCR, 2'd2);
        grant(w);
        chk("t5_order_w", 64'(w), 1);
        serve(w, 20);
        grant(w);
        chk("t5_order_r", 64'(w), 0);
        issue_aw(12'h157, 32'h0000_0C00, 4'd0, INCR, 2'd2);
        serve(w, 20);
        grant(w);
        chk("t5_order_w2", 64'(w), 1);
        serve(w, 0);

        // Reset during the third beat of an eight-beat write.
        issue_aw(12'h066, 32'h0000_0800, 4'd7, INCR, 2'd2);
        grant(w);
        chk("t6_grant_w", 64'(w), 1);
        w_beat(32'h1111_1111, 4'hF, 1'b0);
        w_beat(32'h2222_2222, 4'hF, 1'b0);
        s_if.wdata = 32'h3333_3333; s_if.wstrb = 4'hF; s_if.wlast = 1'b0; s_if.wvalid = 1'b1;
        reset = 1'b1;
        tick();
        check_all_zero("t6_after_reset");
        reset = 1'b0;
        s_if.wvalid = 1'b0;
        s_if.bready = 1'b1;
        b_q.delete();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_no_bvalid", 64'({s_if.bvalid, reg_wr}), 0);
        end
        s_if.bready = 1'b0;
        issue_ar(12'h067, 32'h0000_0900, 4'd0, INCR, 2'd2);
        grant(w);
        chk("t6_grant_r", 64'(w), 0);
        serve(w, 0);

        repeat (3) tick();
        chk("left_wr", 64'(wr_q.size()), 0);
        chk("left_rd", 64'(rd_q.size()), 0);
        chk("left_b", 64'(b_q.size()), 0);
        chk("left_r", 64'(r_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
